// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and flush.
// SKID=1 adds a second slot so in_ready can be a flop.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SKID = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  if (SKID != 0) begin : g_skid

    occ_e              r_state;
    occ_e              w_next;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_push;
    logic              w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_state != EMPTY) && out_ready;

    // Occupancy register and registered in_ready
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state    <= EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_next;
        r_in_ready <= (w_next != FULL);
      end
    end

    // Next occupancy; flush wins over push and pop
    always_comb begin
      w_next = r_state;
      if (flush) begin
        w_next = EMPTY;
      end else begin
        unique case (r_state)
          EMPTY: if (w_push) w_next = ONE;
          ONE: begin
            if (w_push && !w_pop) w_next = FULL;
            else if (!w_push && w_pop) w_next = EMPTY;
          end
          FULL: if (w_pop) w_next = ONE;
          default: w_next = EMPTY;
        endcase
      end
    end

    // Payload slots load only on accepted push or skid-to-main move
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_main <= RESET_VAL;
        r_skid <= RESET_VAL;
      end else if (!flush) begin
        if (r_state == FULL) begin
          if (w_pop) r_main <= r_skid;
        end else if (w_push) begin
          if (r_state == ONE && !w_pop) r_skid <= in_data;
          else r_main <= in_data;
        end
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign count     = r_state;

  end else begin : g_single

    logic              r_valid;
    logic [DATA_W-1:0] r_main;
    logic              w_in_ready;
    logic              w_push;

    assign w_in_ready = !r_valid || out_ready;
    assign w_push     = in_valid && w_in_ready;

    // Single slot valid; a push overrides a pop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= 1'b0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_push) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end

    // Main payload reloads on every accepted push
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_main <= RESET_VAL;
      end else if (w_push && !flush) begin
        r_main <= in_data;
      end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_main;
    assign count     = {1'b0, r_valid};

  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage, skid and single-entry builds.
// Inputs change 1 time unit after the rising edge.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, flush1;
  logic [63:0] in_data1, out_data1;
  logic [1:0]  count1;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, flush0;
  logic [31:0] in_data0, out_data0;
  logic [1:0]  count0;

  int checks;
  int errors;

  pipe_skid_stage #(.DATA_W(64), .SKID(1)) u_skid (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .flush(flush1), .count(count1)
  );

  pipe_skid_stage #(.DATA_W(32), .SKID(0)) u_single (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .flush(flush0), .count(count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid1 = 0; in_data1 = '0; out_ready1 = 0; flush1 = 0;
    in_valid0 = 0; in_data0 = '0; out_ready0 = 0; flush0 = 0;
    #3;
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_count", 64'(count1), 64'd0);
    chk("rst_out_data", out_data1, 64'd0);
    chk("rst_s0_out_valid", 64'(out_valid0), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready1), 64'd1);
    chk("rel_s0_in_ready", 64'(in_ready0), 64'd1);

    // first push: latency 1
    in_valid1 = 1; in_data1 = 64'hA; out_ready1 = 1;
    step();
    chk("lat_out_valid", 64'(out_valid1), 64'd1);
    chk("lat_out_data", out_data1, 64'hA);
    in_valid1 = 0;
    step();
    chk("lat_drain", 64'(out_valid1), 64'd0);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid1 = 1; in_data1 = 64'(i);
      step();
      chk("str_data", out_data1, 64'(i));
      chk("str_valid", 64'(out_valid1), 64'd1);
      chk("str_count", 64'(count1 > 2'd1), 64'd0);
    end
    in_valid1 = 0;
    step();
    chk("str_end_count", 64'(count1), 64'd0);

    // back-pressure
    in_valid1 = 1; in_data1 = 64'h1;
    step();
    chk("bp_head", out_data1, 64'h1);
    out_ready1 = 0; in_data1 = 64'h2;
    step();
    chk("bp_count2", 64'(count1), 64'd2);
    chk("bp_in_ready0", 64'(in_ready1), 64'd0);
    chk("bp_hold_data", out_data1, 64'h1);
    in_valid1 = 0;
    step();
    chk("bp_hold_count", 64'(count1), 64'd2);
    chk("bp_hold_data2", out_data1, 64'h1);
    out_ready1 = 1;
    step();
    chk("bp_second", out_data1, 64'h2);
    chk("bp_count1", 64'(count1), 64'd1);
    chk("bp_in_ready1", 64'(in_ready1), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid1), 64'd0);

    // flush while full with an offered 0x3
    out_ready1 = 0; in_valid1 = 1; in_data1 = 64'h1;
    step();
    in_data1 = 64'h2;
    step();
    chk("fl_pre_count", 64'(count1), 64'd2);
    in_data1 = 64'h3; flush1 = 1;
    step();
    flush1 = 0; in_valid1 = 0;
    chk("fl_out_valid", 64'(out_valid1), 64'd0);
    chk("fl_count", 64'(count1), 64'd0);
    chk("fl_in_ready", 64'(in_ready1), 64'd1);
    chk("fl_no3", 64'(out_data1 == 64'h3), 64'd0);

    // flush with count 1 and an acceptable push of 0x3
    in_valid1 = 1; in_data1 = 64'h7;
    step();
    in_data1 = 64'h3; flush1 = 1;
    step();
    flush1 = 0; in_valid1 = 0;
    chk("fl1_out_valid", 64'(out_valid1), 64'd0);
    chk("fl1_no3", 64'(out_data1 == 64'h3), 64'd0);
    step();
    chk("fl1_stay_empty", 64'(count1), 64'd0);

    // single-entry build
    in_valid0 = 1; in_data0 = 32'h1234;
    step();
    chk("s0_valid", 64'(out_valid0), 64'd1);
    chk("s0_data", 64'(out_data0), 64'h1234);
    chk("s0_in_ready_low", 64'(in_ready0), 64'd0);
    chk("s0_count", 64'(count0), 64'd1);
    out_ready0 = 1; in_data0 = 32'hDEAD;
    #1;
    chk("s0_in_ready_comb", 64'(in_ready0), 64'd1);
    step();
    chk("s0_dead_valid", 64'(out_valid0), 64'd1);
    chk("s0_dead_data", 64'(out_data0), 64'hDEAD);
    in_valid0 = 0;
    step();
    chk("s0_drain", 64'(out_valid0), 64'd0);

    // async reset while full
    out_ready1 = 0; in_valid1 = 1; in_data1 = 64'h5;
    step();
    in_data1 = 64'h6;
    step();
    in_valid1 = 0;
    chk("ar_pre_count", 64'(count1), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid1), 64'd0);
    chk("ar_count", 64'(count1), 64'd0);
    chk("ar_out_data", out_data1, 64'd0);
    chk("ar_in_ready", 64'(in_ready1), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
